// File: rtl/am_pkg.sv
// am_pkg -- shared definitions for 40GBASE-R alignment markers.
// Holds block/lane geometry, the sync header used by markers, the
// per-lane M0..M6 byte constants, marker assembly and the BIP mapping.
// Used by both the transmit inserter and the receive lock/deskew logic.
package am_pkg;

  localparam int AM_BLOCK_W = 66;
  localparam int AM_LANE_N  = 4;
  localparam int AM_GAP_N   = 16383;

  // Sync header carried by every marker block (control block).
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Marker bytes per lane, packed as {M6, M5, M4, M2, M1, M0}.
  // M3 and M7 positions carry BIP3/BIP7 and are not constants.
  localparam logic [47:0] AM_LANE0_BYTES = {8'hb8, 8'h89, 8'h6f, 8'h47, 8'h76, 8'h90};
  localparam logic [47:0] AM_LANE1_BYTES = {8'h19, 8'h3b, 8'h0f, 8'he6, 8'hc4, 8'hf0};
  localparam logic [47:0] AM_LANE2_BYTES = {8'h64, 8'h9a, 8'h3a, 8'h9b, 8'h65, 8'hc5};
  localparam logic [47:0] AM_LANE3_BYTES = {8'hc2, 8'h86, 8'h5d, 8'h3d, 8'h79, 8'ha2};

  // Field positions inside a marker block, LSB first.
  localparam int AM_BIP3_LSB = 26;
  localparam int AM_BIP7_LSB = 58;

  // Constant marker bytes of one lane.
  function automatic logic [47:0] am_lane_bytes(input logic [1:0] lane);
    logic [47:0] bytes;
    case (lane)
      2'd0:    bytes = AM_LANE0_BYTES;
      2'd1:    bytes = AM_LANE1_BYTES;
      2'd2:    bytes = AM_LANE2_BYTES;
      2'd3:    bytes = AM_LANE3_BYTES;
      default: bytes = AM_LANE0_BYTES;
    endcase
    return bytes;
  endfunction

  // Full 66b marker for a lane with the given BIP3; BIP7 is its complement.
  function automatic logic [AM_BLOCK_W-1:0] am_marker(input logic [1:0] lane,
                                                      input logic [7:0] bip3);
    logic [47:0] m;
    m = am_lane_bytes(lane);
    //       BIP7   M6        M5        M4        BIP3  M2        M1       M0      sync
    return {~bip3, m[47:40], m[39:32], m[31:24], bip3, m[23:16], m[15:8], m[7:0], SYNC_CTRL};
  endfunction

  // Block parity: bit k covers block bits k+2, k+10, ..., k+58; bit 3 also
  // folds in block bit 0 and bit 4 folds in block bit 1 (the sync header).
  function automatic logic [7:0] am_bip_calc(input logic [AM_BLOCK_W-1:0] blk);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        p[k] = p[k] ^ blk[k + 2 + 8 * j];
      end
    end
    p[3] = p[3] ^ blk[0];
    p[4] = p[4] ^ blk[1];
    return p;
  endfunction

  // BIP3 field of a received or transmitted marker block.
  function automatic logic [7:0] am_bip3_field(input logic [AM_BLOCK_W-1:0] blk);
    return blk[AM_BIP3_LSB +: 8];
  endfunction

  // BIP7 field of a received or transmitted marker block.
  function automatic logic [7:0] am_bip7_field(input logic [AM_BLOCK_W-1:0] blk);
    return blk[AM_BIP7_LSB +: 8];
  endfunction

endpackage

// File: rtl/am_bip_tx.sv
// am_bip_tx -- per-lane running BIP for the transmit marker inserter.
// Accumulates parity over every block emitted on its lane; on a marker
// it presents the running value as BIP3 and restarts from the parity of
// the marker that carried it. Present only when AM_TX_BIP_EN is defined.
`ifdef AM_TX_BIP_EN
module am_bip_tx
  import am_pkg::*;
#(
  parameter logic [1:0] LANE_ID = 2'd0
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  blk_v,
  input  logic                  am_slot,
  input  logic [AM_BLOCK_W-1:0] blk,
  output logic [7:0]            bip3
);

  logic [7:0]            bip_r;
  logic [AM_BLOCK_W-1:0] marker_s;
  logic [7:0]            reload_s;
  logic [7:0]            data_par_s;
  logic [7:0]            bip_nxt_s;

  // Marker leaving this cycle and the parity that restarts the next period.
  always_comb begin
    marker_s   = am_marker(LANE_ID, bip_r);
    reload_s   = am_bip_calc(marker_s);
    data_par_s = am_bip_calc(blk);
  end

  // Choose the next running parity: marker reload, data accumulate, or hold.
  always_comb begin
    bip_nxt_s = bip_r;
    if (blk_v) begin
      if (am_slot) begin
        bip_nxt_s = reload_s;
      end else begin
        bip_nxt_s = bip_r ^ data_par_s;
      end
    end else begin
      bip_nxt_s = bip_r;
    end
  end

  // Running parity register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bip_r <= 8'h00;
    end else begin
      bip_r <= bip_nxt_s;
    end
  end

  assign bip3 = bip_r;

endmodule
`endif

// File: rtl/am_insert_tx.sv
// am_insert_tx -- transmit alignment marker insertion, 4-lane 40GBASE-R.
// After every GAP_N accepted blocks per lane one marker is emitted on all
// lanes at once; upstream is stalled (ready_o low) for that single cycle.
// Build option: define AM_TX_BIP_EN to compute real BIP3/BIP7; without it
// markers carry BIP3=8'h00 and BIP7=8'hff.
module am_insert_tx
  import am_pkg::*;
#(
  parameter int BLOCK_W = AM_BLOCK_W,
  parameter int LANE_N  = AM_LANE_N,
  parameter int GAP_N   = AM_GAP_N
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      valid_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o,
  output logic                      am_v_o
);

  localparam int GAP_W = $clog2(GAP_N + 1);

  logic [GAP_W-1:0]          gap_r;
  logic                      am_slot_s;
  logic [7:0]                bip3_s [LANE_N];
  logic [LANE_N*BLOCK_W-1:0] nxt_data_s;
  logic [GAP_W-1:0]          gap_nxt_s;

  // The marker slot depends only on the counter, so ready_o never loops
  // back through valid_i.
  assign am_slot_s = (gap_r == GAP_W'(GAP_N));
  assign ready_o   = ~am_slot_s;

`ifdef AM_TX_BIP_EN
  for (genvar g = 0; g < LANE_N; g++) begin : g_bip
    am_bip_tx #(
      .LANE_ID (2'(g))
    ) u_bip (
      .clk     (clk),
      .nreset  (nreset),
      .blk_v   (valid_i),
      .am_slot (am_slot_s),
      .blk     (data_i[g*BLOCK_W +: BLOCK_W]),
      .bip3    (bip3_s[g])
    );
  end
`else
  for (genvar g = 0; g < LANE_N; g++) begin : g_nobip
    assign bip3_s[g] = 8'h00;
  end
`endif

  // Per-lane output block: lane marker in the marker slot, else the input.
  always_comb begin
    nxt_data_s = '0;
    for (int l = 0; l < LANE_N; l++) begin
      if (am_slot_s) begin
        nxt_data_s[l*BLOCK_W +: BLOCK_W] = am_marker(2'(l), bip3_s[l]);
      end else begin
        nxt_data_s[l*BLOCK_W +: BLOCK_W] = data_i[l*BLOCK_W +: BLOCK_W];
      end
    end
  end

  // Next gap count: restart after a marker, advance on accepted data.
  always_comb begin
    gap_nxt_s = gap_r;
    if (valid_i) begin
      if (am_slot_s) begin
        gap_nxt_s = {GAP_W{1'b0}};
      end else begin
        gap_nxt_s = gap_r + GAP_W'(1);
      end
    end else begin
      gap_nxt_s = gap_r;
    end
  end

  // Gap counter; resets to the marker slot so the first output is a marker.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gap_r <= GAP_W'(GAP_N);
    end else begin
      gap_r <= gap_nxt_s;
    end
  end

  // Registered outputs, one cycle after the accept/marker decision.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_o <= 1'b0;
      am_v_o  <= 1'b0;
      data_o  <= '0;
    end else if (valid_i) begin
      valid_o <= 1'b1;
      am_v_o  <= am_slot_s;
      data_o  <= nxt_data_s;
    end else begin
      valid_o <= 1'b0;
      am_v_o  <= 1'b0;
      data_o  <= data_o;
    end
  end

endmodule

// File: tb/tb_am_insert_tx.sv
// tb_am_insert_tx -- self-checking bench for am_insert_tx with GAP_N=4.
// A queue-free behavioural model predicts each output cycle from the
// marker period, the lane marker table and a bit-by-bit parity sum;
// literal expectations pin the first marker and the second marker's BIP.
module tb_am_insert_tx;

  localparam int GAP = 4;
  localparam int LN  = 4;
  localparam int BW  = 66;
  localparam int DW  = LN * BW;
`ifdef AM_TX_BIP_EN
  localparam bit BIP_EN = 1'b1;
`else
  localparam bit BIP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nreset = 1'b1;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          am_v_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  am_insert_tx #(.GAP_N(GAP)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .am_v_o  (am_v_o)
  );

  // Marker table: M0, M1, M2, M4, M5, M6 per lane.
  logic [7:0] mtab [LN][6] = '{
    '{8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8},
    '{8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19},
    '{8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64},
    '{8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2}
  };

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Byte fields after the sync header: M0 M1 M2 BIP3 M4 M5 M6 BIP7.
  function automatic logic [65:0] marker_blk(input int lane, input logic [7:0] b3);
    logic [65:0] b;
    logic [7:0]  f [8];
    f[0] = mtab[lane][0]; f[1] = mtab[lane][1]; f[2] = mtab[lane][2];
    f[3] = b3;
    f[4] = mtab[lane][3]; f[5] = mtab[lane][4]; f[6] = mtab[lane][5];
    f[7] = ~b3;
    b = '0;
    b[1:0] = 2'b10;
    for (int i = 0; i < 8; i++) b[2 + 8*i +: 8] = f[i];
    return b;
  endfunction

  // Each block bit n>=2 lands in parity bit (n-2) mod 8; sync bits 0/1 in bits 3/4.
  function automatic logic [7:0] blk_par(input logic [65:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int n = 2; n < 66; n++) p[(n-2) % 8] = p[(n-2) % 8] ^ b[n];
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
    return t[DW-1:0];
  endfunction

  // ---------------- behavioural model ----------------
  int            acc;          // data blocks accepted since the last marker
  logic [7:0]    mbip [LN];
  logic          exp_v;
  logic          exp_am;
  logic [DW-1:0] exp_d;
  bit            cmp_en = 1'b0;

  // Model: predict the output of each decision cycle.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc    <= GAP;
      exp_v  <= 1'b0;
      exp_am <= 1'b0;
      exp_d  <= '0;
      for (int l = 0; l < LN; l++) mbip[l] <= 8'h00;
    end else if (valid_i) begin
      exp_v <= 1'b1;
      if (acc == GAP) begin
        exp_am <= 1'b1;
        acc    <= 0;
        for (int l = 0; l < LN; l++) begin
          exp_d[l*BW +: BW] <= marker_blk(l, BIP_EN ? mbip[l] : 8'h00);
          mbip[l]           <= blk_par(marker_blk(l, BIP_EN ? mbip[l] : 8'h00));
        end
      end else begin
        exp_am <= 1'b0;
        acc    <= acc + 1;
        exp_d  <= data_i;
        for (int l = 0; l < LN; l++) mbip[l] <= mbip[l] ^ blk_par(data_i[l*BW +: BW]);
      end
    end else begin
      exp_v  <= 1'b0;
      exp_am <= 1'b0;
    end
  end

  // Compare: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready_o", {65'd0, ready_o}, (acc != GAP) ? 66'd1 : 66'd0);
      chk("valid_o", {65'd0, valid_o}, {65'd0, exp_v});
      chk("am_v_o",  {65'd0, am_v_o},  {65'd0, exp_am});
      if (exp_v) begin
        for (int l = 0; l < LN; l++) chk("data_o_lane", data_o[l*BW +: BW], exp_d[l*BW +: BW]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic took = 1'b1;

  // Present a new block only once the previous one was consumed.
  task automatic drive(input logic v, input bit fresh);
    if (fresh && took) data_i = rnd();
    valid_i = v;
    took = v && ready_o;
  endtask

  logic [65:0] lane0_am0;
  logic [7:0]  exp_b3;

  initial begin
    lane0_am0 = {8'hff, 8'hb8, 8'h89, 8'h6f, 8'h00, 8'h47, 8'h76, 8'h90, 2'b10};
`ifdef AM_TX_BIP_EN
    exp_b3 = 8'h10;   // parity of any first marker; the four equal data blocks cancel
`else
    exp_b3 = 8'h00;
`endif
    #1 nreset = 1'b0;
    #1;
    chk("rst_valid_o", {65'd0, valid_o}, 66'd0);
    chk("rst_am_v_o",  {65'd0, am_v_o},  66'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_o", {65'd0, ready_o}, 66'd0);
    chk("rst_data_o",  {65'd0, |data_o}, 66'd0);
    data_i = rnd();

    // Phase 1: constant data, continuous valid.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        nreset = 1'b1;
        cmp_en = 1'b1;
      end
      chk("ready_pattern", {65'd0, ready_o}, (i % 5 == 0) ? 66'd0 : 66'd1);
      if (i == 1) begin
        chk("am0_valid_o", {65'd0, valid_o}, 66'd1);
        chk("am0_am_v_o",  {65'd0, am_v_o},  66'd1);
        chk("am0_lane0",   data_o[65:0], lane0_am0);
      end
      if (i == 6) begin
        chk("am1_am_v_o", {65'd0, am_v_o}, 66'd1);
        for (int l = 0; l < LN; l++) begin
          chk("am1_bip3", {58'd0, data_o[l*BW + 26 +: 8]}, {58'd0, exp_b3});
          chk("am1_bip7", {58'd0, data_o[l*BW + 58 +: 8]}, {58'd0, ~exp_b3});
        end
      end
      drive(1'b1, 1'b0);
    end

    // Phase 2: continuous valid, fresh data.
    repeat (12) begin
      @(negedge clk);
      drive(1'b1, 1'b1);
    end

    // Phase 3: valid toggling 1,0.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive((i % 2) == 0, 1'b1);
    end

    // Phase 4: asynchronous reset in mid-period.
    repeat (7) begin
      @(negedge clk);
      drive(1'b1, 1'b1);
    end
    @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("arst_valid_o", {65'd0, valid_o}, 66'd0);
    chk("arst_am_v_o",  {65'd0, am_v_o},  66'd0);
    chk("arst_data_o",  {65'd0, |data_o}, 66'd0);
    @(negedge clk);
    drive(1'b1, 1'b1);
    @(negedge clk);
    nreset = 1'b1;
    drive(1'b1, 1'b1);
    @(negedge clk);
    chk("post_rst_am_v_o", {65'd0, am_v_o}, 66'd1);
    for (int l = 0; l < LN; l++) begin
      chk("post_rst_bip3", {58'd0, data_o[l*BW + 26 +: 8]}, 66'd0);
      chk("post_rst_bip7", {58'd0, data_o[l*BW + 58 +: 8]}, 66'hff);
    end
    drive(1'b1, 1'b1);
    repeat (8) begin
      @(negedge clk);
      drive(1'b1, 1'b1);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
